// File: rtl/led_out_pkg.sv
// Shared types and default constants for the LED blink output block.
// The state encoding is shared by every channel instance; the defaults
// match a 50 MHz clock with a 40 Hz timebase.
package led_out_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CYCLE_DEF     = 1250000;  // clk cycles per tick
  localparam int N_DEF         = 3;        // LED channels
  localparam int ON_TICKS_DEF  = 4;        // lit ticks per blink
  localparam int OFF_TICKS_DEF = 4;        // dark ticks after each blink
  localparam int MAX_PEND_DEF  = 7;        // queued requests per channel

endpackage

// File: rtl/led_ch.sv
// One LED channel: saturating request counter, IDLE/ON/GAP blink FSM with
// a tick-based phase counter, and a registered overflow pulse.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   tick      - one-cycle timebase strobe shared by all channels
//   pulse     - one-cycle blink request
//   led_n     - active-low LED drive (registered)
//   busy      - blinking or requests pending
//   ovf       - one-cycle pulse: a request was dropped (queue full)
module led_ch
  import led_out_pkg::*;
#(
  parameter int ON_TICKS  = ON_TICKS_DEF,
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int MAX_PEND  = MAX_PEND_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pulse,
  output logic led_n,
  output logic busy,
  output logic ovf
);

  localparam int PW   = $clog2(MAX_PEND + 1);
  localparam int PMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PHW  = $clog2(PMAX + 1);

  state_t          state, state_nxt;
  logic [PHW-1:0]  ph, ph_nxt;
  logic [PW-1:0]   pend;
  logic            take;   // a blink starts this cycle and consumes a request

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    take      = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (pend != '0) begin
            state_nxt = ON;
            ph_nxt    = '0;
            take      = 1'b1;
          end
        end
        ON: begin
          if (ph == PHW'(ON_TICKS - 1)) begin
            state_nxt = GAP;
            ph_nxt    = '0;
          end else begin
            ph_nxt = ph + PHW'(1);
          end
        end
        GAP: begin
          if (ph == PHW'(OFF_TICKS - 1)) begin
            ph_nxt = '0;
            // Chain straight into the next blink when work is queued.
            if (pend != '0) begin
              state_nxt = ON;
              take      = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            ph_nxt = ph + PHW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          ph_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph    <= '0;
      pend  <= '0;
      led_n <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      ph    <= ph_nxt;
      // Own flop tracking the ON state so the pin never sees decode glitches.
      led_n <= (state_nxt != ON);
      ovf   <= 1'b0;
      // Simultaneous request and consume cancel out, even when full.
      if (pulse && !take) begin
        if (pend == PW'(MAX_PEND)) ovf <= 1'b1;
        else                       pend <= pend + PW'(1);
      end else if (take && !pulse) begin
        pend <= pend - PW'(1);
      end
    end
  end

  assign busy = (state != IDLE) || (pend != '0);

endmodule

// File: rtl/led_out.sv
// LED blink output stage: N independent channels turning one-cycle event
// pulses into visible active-low blinks, paced by a shared timebase.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   pulse_in[N-1:0] - one-cycle blink requests
//   led_n[N-1:0]    - active-low LED drives (registered)
//   busy[N-1:0]     - channel blinking or has pending requests
//   ovf[N-1:0]      - one-cycle pulse when a request was dropped
module led_out
  import led_out_pkg::*;
#(
  parameter int CYCLE     = CYCLE_DEF,
  parameter int N         = N_DEF,
  parameter int ON_TICKS  = ON_TICKS_DEF,
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int MAX_PEND  = MAX_PEND_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pulse_in,
  output logic [N-1:0] led_n,
  output logic [N-1:0] busy,
  output logic [N-1:0] ovf
);

  localparam int TW = $clog2(CYCLE + 1);

  logic [TW-1:0] tcnt;
  logic          tick;

  assign tick = (tcnt == TW'(CYCLE - 1));

  always_ff @(posedge clk) begin
    if (rst)       tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + TW'(1);
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    led_ch #(
      .ON_TICKS (ON_TICKS),
      .OFF_TICKS(OFF_TICKS),
      .MAX_PEND (MAX_PEND)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .pulse(pulse_in[i]),
      .led_n(led_n[i]),
      .busy (busy[i]),
      .ovf  (ovf[i])
    );
  end

endmodule

// File: tb/tb_led_out.sv
// Bench for led_out: a tick-schedule reference model (blink start ticks,
// request counts) checked every cycle, plus directed duration checks.
module tb_led_out;

  localparam int CYCLE = 10;
  localparam int N     = 3;
  localparam int ONT   = 2;
  localparam int OFFT  = 1;
  localparam int MAXP  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pulse_in;
  logic [N-1:0] led_n, busy, ovf;

  led_out #(.CYCLE(CYCLE), .N(N), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .MAX_PEND(MAXP)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .led_n(led_n), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: time counted in clk cycles and tick indices. A blink
  // starting at tick s is lit for ticks [s, s+ONT) and blocks the channel
  // until tick s+ONT+OFFT.
  int           m_mt, m_tk;
  int           m_pend [N];
  int           m_ls   [N];
  int           m_free [N];
  logic [N-1:0] m_ovf;
  bit           m_valid = 1'b0;
  bit           m_tick, m_inc, m_dec;

  always @(posedge clk) begin
    if (rst) begin
      m_mt = 0; m_tk = 0; m_ovf = '0; m_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_ls[i] = -100; m_free[i] = 0;
      end
    end else begin
      m_tick = (m_mt == CYCLE - 1);
      m_mt   = m_tick ? 0 : m_mt + 1;
      if (m_tick) m_tk++;
      for (int i = 0; i < N; i++) begin
        m_inc    = pulse_in[i];
        m_dec    = m_tick && (m_pend[i] > 0) && (m_tk >= m_free[i]);
        m_ovf[i] = m_inc && !m_dec && (m_pend[i] == MAXP);
        if (m_dec) begin
          m_ls[i]   = m_tk;
          m_free[i] = m_tk + ONT + OFFT;
        end
        if (m_inc && !m_dec && m_pend[i] < MAXP) m_pend[i]++;
        else if (m_dec && !m_inc)                m_pend[i]--;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int blk [N];
  int ovc [N];
  logic [N-1:0] prev_led = '1;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge, compare against the model,
  // and track blink / overflow counts for the directed checks.
  task automatic step();
    logic exp_led, exp_busy;
    @(negedge clk);
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        exp_led  = !((m_tk - m_ls[i]) < ONT);
        exp_busy = (m_pend[i] > 0) || (m_tk < m_ls[i] + ONT + OFFT);
        total += 3;
        if (led_n[i] !== exp_led) begin
          bad++; $display("FAIL led_n[%0d] got=%b exp=%b t=%0t", i, led_n[i], exp_led, $time);
        end
        if (busy[i] !== exp_busy) begin
          bad++; $display("FAIL busy[%0d] got=%b exp=%b t=%0t", i, busy[i], exp_busy, $time);
        end
        if (ovf[i] !== m_ovf[i]) begin
          bad++; $display("FAIL ovf[%0d] got=%b exp=%b t=%0t", i, ovf[i], m_ovf[i], $time);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (prev_led[i] && !led_n[i]) blk[i]++;
      if (ovf[i] === 1'b1) ovc[i]++;
    end
    prev_led = led_n;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; pulse_in = '0;
    repeat (n) step();
  endtask

  initial begin
    int n, b0, o0;
    for (int i = 0; i < N; i++) begin blk[i] = 0; ovc[i] = 0; end
    rst = 1'b1; pulse_in = '0;

    // Reset state, checked one cycle after the first reset edge.
    step();
    chk("rst_led_n", int'(led_n), 7);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_ovf",   int'(ovf), 0);
    step(); step();

    // Single blink on channel 0: first tick 10 cycles after release.
    rst = 1'b0; pulse_in = 3'b001; step(); pulse_in = '0;
    n = 1;
    while (led_n[0] && n < 50) begin step(); n++; end
    chk("single_first_on", n, 10);
    n = 0;
    while (!led_n[0] && n < 100) begin step(); n++; end
    chk("single_on_len", n, 20);
    n = 0;
    while (busy[0] && led_n[0] && n < 100) begin step(); n++; end
    chk("single_gap_len", n, 10);
    chk("single_others_idle", int'(busy[2:1]), 0);

    // Three queued requests on channel 1.
    do_reset(3);
    rst = 1'b0; b0 = blk[1];
    pulse_in = 3'b010; repeat (3) step(); pulse_in = '0;
    n = 0;
    while (led_n[1] && n < 50) begin step(); n++; end
    n = 0;
    while (busy[1] && n < 300) begin step(); n++; end
    chk("triple_busy_len", n, 90);
    chk("triple_blinks", blk[1] - b0, 3);

    // Five requests on channel 2: two dropped.
    do_reset(3);
    rst = 1'b0; b0 = blk[2]; o0 = ovc[2];
    pulse_in = 3'b100; repeat (5) step(); pulse_in = '0;
    repeat (150) step();
    chk("ovf_count", ovc[2] - o0, 2);
    chk("ovf_blinks", blk[2] - b0, 3);

    // Request landing on a tick while idle lights at the following tick.
    do_reset(3);
    rst = 1'b0; step();
    repeat (8) step();
    pulse_in = 3'b001; step(); pulse_in = '0;
    n = 0;
    while (led_n[0] && n < 50) begin step(); n++; end
    chk("tick_pulse_delay", n, 10);
    repeat (30) step();

    // Full queue plus a request on the consuming tick: nothing dropped.
    do_reset(3);
    rst = 1'b0; b0 = blk[0]; o0 = ovc[0];
    pulse_in = 3'b001; repeat (3) step(); pulse_in = '0;
    repeat (6) step();
    pulse_in = 3'b001; step(); pulse_in = '0;
    repeat (200) step();
    chk("full_tick_no_ovf", ovc[0] - o0, 0);
    chk("full_tick_blinks", blk[0] - b0, 4);

    // Reset mid-blink discards the queue.
    do_reset(3);
    rst = 1'b0;
    pulse_in = 3'b010; repeat (3) step(); pulse_in = '0;
    n = 0;
    while (led_n[1] && n < 50) begin step(); n++; end
    step();
    rst = 1'b1; step();
    chk("midrst_led_n", int'(led_n), 7);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0; b0 = blk[1];
    repeat (100) step();
    chk("midrst_no_blinks", blk[1] - b0, 0);
    chk("midrst_idle", int'(busy), 0);

    // Random traffic with occasional resets; the model checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) pulse_in[i] = ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0; pulse_in = '0;
    repeat (200) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
